// File: rtl/mmss_timer_pkg.sv
// Shared definitions for the MM:SS countdown/countup timer: state encoding,
// BCD digit width, terminal values and the seconds-to-BCD preset conversion.
package mmss_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD_W   = 4 * DIGIT_W;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

  localparam logic [BCD_W-1:0] TERM_DOWN = '0;

  function automatic logic [BCD_W-1:0] term_up(input int unsigned max_min);
    return {DIGIT_W'(max_min / 10), DIGIT_W'(max_min % 10), SEC_TENS_MAX, DIGIT_MAX};
  endfunction

  // Presets beyond the displayable range saturate to max_min:59.
  function automatic logic [BCD_W-1:0] secs_to_bcd(input int unsigned v,
                                                   input int unsigned max_min);
    int unsigned m;
    int unsigned s;
    if (v > max_min * 60 + 59) begin
      m = max_min;
      s = 59;
    end else begin
      m = v / 60;
      s = v % 60;
    end
    return {DIGIT_W'(m / 10), DIGIT_W'(m % 10), DIGIT_W'(s / 10), DIGIT_W'(s % 10)};
  endfunction

endpackage

// File: rtl/mmss_timer_tick.sv
// Prescaler: counts 0..CLK_DIV-1 while enabled and flags the last count as a
// one-cycle tick; holding when disabled keeps the fractional second.
module tick_gen #(
  parameter int unsigned CLK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mmss_timer.sv
// MM:SS timer with load/start/pause control, up or down counting in BCD and
// a DONE state reached when the count hits its terminal value.
module mmss_timer
  import mmss_timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100_000_000,
  parameter int unsigned LOAD_W  = 8,
  parameter int unsigned MAX_MIN = 99
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LOAD_W-1:0] load_value,
  input  logic              load,
  input  logic              start_stop,
  input  logic              mode_up,
  output logic [15:0]       bcd_out,
  output logic              running,
  output logic              done,
  output logic              expired
);

  localparam logic [BCD_W-1:0] TERM_UP = term_up(MAX_MIN);

  state_t           state_q, state_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_step, load_bcd;
  logic             mode_q, mode_d;
  logic             done_q;
  logic             tick;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == ST_RUN),
    .clear  (load),
    .tick   (tick)
  );

  function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] cur,
                                                input logic up);
    logic [DIGIT_W-1:0] m10, m1, s10, s1;
    {m10, m1, s10, s1} = cur;
    if (up) begin
      if (s1 != DIGIT_MAX) s1 = s1 + 1'b1;
      else begin
        s1 = '0;
        if (s10 != SEC_TENS_MAX) s10 = s10 + 1'b1;
        else begin
          s10 = '0;
          if (m1 != DIGIT_MAX) m1 = m1 + 1'b1;
          else begin
            m1  = '0;
            m10 = m10 + 1'b1;
          end
        end
      end
    end else begin
      if (s1 != '0) s1 = s1 - 1'b1;
      else begin
        s1 = DIGIT_MAX;
        if (s10 != '0) s10 = s10 - 1'b1;
        else begin
          s10 = SEC_TENS_MAX;
          if (m1 != '0) m1 = m1 - 1'b1;
          else begin
            m1  = DIGIT_MAX;
            m10 = m10 - 1'b1;
          end
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  assign load_bcd = secs_to_bcd(32'(load_value), MAX_MIN);
  assign bcd_step = bcd_next(bcd_q, mode_q);

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    mode_d  = mode_q;
    if (load) begin
      state_d = ST_IDLE;
      bcd_d   = load_bcd;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_stop && (bcd_q != (mode_up ? TERM_UP : TERM_DOWN))) begin
            state_d = ST_RUN;
            mode_d  = mode_up;
          end
        end
        ST_RUN: begin
          // A tick landing on the terminal value wins over a pause request.
          if (tick) begin
            bcd_d = bcd_step;
            if (bcd_step == (mode_q ? TERM_UP : TERM_DOWN)) state_d = ST_DONE;
            else if (start_stop)                             state_d = ST_PAUSE;
          end else if (start_stop) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start_stop) state_d = ST_RUN;
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      mode_q  <= mode_d;
      done_q  <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  assign bcd_out = bcd_q;
  assign running = (state_q == ST_RUN);
  assign expired = (state_q == ST_DONE);
  assign done    = done_q;

endmodule

// File: tb/tb_mmss_timer.sv
// Directed bench for mmss_timer: load-conversion table on two instances
// (MAX_MIN 99 and 3) plus hand-written run/pause/done/reset sequences.
module tb_mmss_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        start_stop = 1'b0;
  logic        mode_up = 1'b0;
  logic [7:0]  load_value = '0;
  logic [15:0] bcd_a, bcd_b;
  logic        run_a, run_b, done_a, done_b, exp_a, exp_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mmss_timer #(.CLK_DIV(4), .LOAD_W(8), .MAX_MIN(99)) dut (
    .clk(clk), .reset(reset), .load_value(load_value), .load(load),
    .start_stop(start_stop), .mode_up(mode_up), .bcd_out(bcd_a),
    .running(run_a), .done(done_a), .expired(exp_a)
  );

  mmss_timer #(.CLK_DIV(4), .LOAD_W(8), .MAX_MIN(3)) dut3 (
    .clk(clk), .reset(reset), .load_value(load_value), .load(load),
    .start_stop(start_stop), .mode_up(mode_up), .bcd_out(bcd_b),
    .running(run_b), .done(done_b), .expired(exp_b)
  );

  typedef struct {
    logic [7:0]  v;
    logic [15:0] exp99;
    logic [15:0] exp3;
  } load_vec_t;

  load_vec_t vecs[9];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [7:0] v);
    load_value = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'd0,   16'h0000, 16'h0000};
    vecs[1] = '{8'd59,  16'h0059, 16'h0059};
    vecs[2] = '{8'd60,  16'h0100, 16'h0100};
    vecs[3] = '{8'd75,  16'h0115, 16'h0115};
    vecs[4] = '{8'd119, 16'h0159, 16'h0159};
    vecs[5] = '{8'd200, 16'h0320, 16'h0320};
    vecs[6] = '{8'd239, 16'h0359, 16'h0359};
    vecs[7] = '{8'd255, 16'h0415, 16'h0359};
    vecs[8] = '{8'd240, 16'h0400, 16'h0359};

    // Reset state
    cyc(2);
    check("reset_bcd", bcd_a, 16'h0000);
    check_bit("reset_running", run_a, 1'b0);
    check_bit("reset_done", done_a, 1'b0);
    check_bit("reset_expired", exp_a, 1'b0);
    reset = 1'b0;
    cyc(1);

    // Load conversion and saturation
    for (int i = 0; i < 9; i++) begin
      pulse_load(vecs[i].v);
      check("load_bcd99", bcd_a, vecs[i].exp99);
      check("load_bcd3", bcd_b, vecs[i].exp3);
      check_bit("load_idle", run_a, 1'b0);
    end

    // Saturated 03:59 is already terminal in up mode
    mode_up = 1'b1;
    pulse_ss();
    check_bit("sat_up_ignored_run", run_b, 1'b0);
    check_bit("sat_up_ignored_exp", exp_b, 1'b0);
    check("sat_up_hold", bcd_b, 16'h0359);
    mode_up = 1'b0;

    // Zero preset in down mode cannot start
    pulse_load(8'd0);
    pulse_ss();
    for (int i = 0; i < 8; i++) begin
      check_bit("zero_no_run", run_a, 1'b0);
      check_bit("zero_no_done", done_a, 1'b0);
      cyc(1);
    end

    // Up count with carry into minutes; mode_up ignored mid-run
    pulse_load(8'd119);
    mode_up = 1'b1;
    pulse_ss();
    mode_up = 1'b0;
    check_bit("up_running", run_a, 1'b1);
    cyc(3);
    check("up_before_tick", bcd_a, 16'h0159);
    cyc(1);
    check("up_carry_min", bcd_a, 16'h0200);
    cyc(4);
    check("up_mode_latched", bcd_a, 16'h0201);

    // Pause two cycles into a second, hold ten cycles, resume
    cyc(1);
    pulse_ss();
    check_bit("pause_running", run_a, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("pause_frozen", bcd_a, 16'h0201);
      cyc(1);
    end
    pulse_ss();
    check_bit("resume_running", run_a, 1'b1);
    cyc(1);
    check("resume_pre_tick", bcd_a, 16'h0201);
    cyc(1);
    check("resume_tick_2cyc", bcd_a, 16'h0202);

    // Load and start_stop together while running at 00:30
    pulse_load(8'd30);
    pulse_ss();
    cyc(2);
    load_value = 8'd45;
    load = 1'b1;
    start_stop = 1'b1;
    cyc(1);
    load = 1'b0;
    start_stop = 1'b0;
    check("load_wins_bcd", bcd_a, 16'h0045);
    check_bit("load_wins_idle", run_a, 1'b0);

    // Load on the tick edge discards the tick and clears the prescaler
    pulse_ss();
    cyc(3);
    load_value = 8'd20;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("load_vs_tick", bcd_a, 16'h0020);
    pulse_ss();
    cyc(3);
    check("reload_pre_tick", bcd_a, 16'h0020);
    cyc(1);
    check("reload_tick", bcd_a, 16'h0019);

    // Reset mid-run overrides load and start_stop
    cyc(5);
    check_bit("prereset_running", run_a, 1'b1);
    reset = 1'b1;
    load = 1'b1;
    load_value = 8'd99;
    start_stop = 1'b1;
    cyc(1);
    reset = 1'b0;
    load = 1'b0;
    start_stop = 1'b0;
    check("midrun_reset_bcd", bcd_a, 16'h0000);
    check_bit("midrun_reset_run", run_a, 1'b0);
    cyc(5);
    check("postreset_idle", bcd_a, 16'h0000);
    check_bit("postreset_run", run_a, 1'b0);

    // Full countdown from 01:15 to DONE
    pulse_load(8'd75);
    check("cd_load", bcd_a, 16'h0115);
    pulse_ss();
    check_bit("cd_running", run_a, 1'b1);
    cyc(3);
    check("cd_pre_tick", bcd_a, 16'h0115);
    cyc(1);
    check("cd_first_tick", bcd_a, 16'h0114);
    cyc(60);
    check("cd_borrow_min", bcd_a, 16'h0059);
    cyc(235);
    check("cd_one_left", bcd_a, 16'h0001);
    check_bit("cd_no_early_done", done_a, 1'b0);
    cyc(1);
    check("cd_zero", bcd_a, 16'h0000);
    check_bit("cd_done_pulse", done_a, 1'b1);
    check_bit("cd_expired", exp_a, 1'b1);
    check_bit("cd_not_running", run_a, 1'b0);
    cyc(1);
    check_bit("cd_done_one_cycle", done_a, 1'b0);
    check_bit("cd_expired_hold", exp_a, 1'b1);
    pulse_ss();
    check_bit("done_ignores_ss", exp_a, 1'b1);
    check_bit("done_ignores_ss_run", run_a, 1'b0);
    cyc(8);
    check("done_bcd_hold", bcd_a, 16'h0000);
    check_bit("done_no_repulse", done_a, 1'b0);
    pulse_load(8'd5);
    check_bit("load_leaves_done", exp_a, 1'b0);
    check("load_after_done", bcd_a, 16'h0005);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
